// File: rtl/tiro_pkg.sv
// tiro shared constants, selector/opcode encodings and the memory entry layout.
package tiro_pkg;

  localparam int unsigned COORD_W   = 4;
  localparam int unsigned N_ENTRIES = 16;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned OP_W      = 2;
  localparam int unsigned SUM_W     = COORD_W + 1;

  // Position write source
  typedef enum logic [1:0] {
    POS_EXT   = 2'b00,
    POS_ADDER = 2'b01,
    POS_SHIP  = 2'b10,
    POS_HOLD  = 2'b11
  } pos_sel_e;

  // Direction opcode, encoded as {axis, subtract}
  typedef enum logic [1:0] {
    OP_X_INC = 2'b00,
    OP_X_DEC = 2'b01,
    OP_Y_INC = 2'b10,
    OP_Y_DEC = 2'b11
  } opcode_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [OP_W-1:0]    opcode;
    logic               loaded;
    logic               destruido;
  } entry_t;

endpackage

// File: rtl/tiro_if.sv
// tiro control/status bundle; slave = the tiro block, master = whoever drives it.
interface tiro_if;
  import tiro_pkg::*;

  logic               conta_contador;
  logic               reset_cont;
  logic [1:0]         select_mux_pos;
  logic               select_mux_coor;
  logic               select_soma_sub;
  logic               enable_reg_nave;
  logic               reset_reg_nave;
  logic               enable_mem_aste;
  logic               enable_mem_load;
  logic [COORD_W-1:0] aste_coor_x;
  logic [COORD_W-1:0] aste_coor_y;
  logic               new_load;
  logic               new_destruido;

  logic               x_borda_min;
  logic               x_borda_max;
  logic               y_borda_min;
  logic               y_borda_max;
  logic               colisao;
  logic               rco_contador;
  logic               loaded;
  logic [OP_W-1:0]    opcode;
  logic [IDX_W-1:0]   db_contador;
  logic [SUM_W-1:0]   db_wire_saida_som_sub;

  modport slave (
    input  conta_contador, reset_cont, select_mux_pos, select_mux_coor,
           select_soma_sub, enable_reg_nave, reset_reg_nave, enable_mem_aste,
           enable_mem_load, aste_coor_x, aste_coor_y, new_load, new_destruido,
    output x_borda_min, x_borda_max, y_borda_min, y_borda_max, colisao,
           rco_contador, loaded, opcode, db_contador, db_wire_saida_som_sub
  );

  modport master (
    output conta_contador, reset_cont, select_mux_pos, select_mux_coor,
           select_soma_sub, enable_reg_nave, reset_reg_nave, enable_mem_aste,
           enable_mem_load, aste_coor_x, aste_coor_y, new_load, new_destruido,
    input  x_borda_min, x_borda_max, y_borda_min, y_borda_max, colisao,
           rco_contador, loaded, opcode, db_contador, db_wire_saida_som_sub
  );

endinterface

// File: rtl/tiro_mem.sv
// 16-entry register file with synchronous clear; independent position, opcode and flag write strobes.
module tiro_mem
  import tiro_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [IDX_W-1:0]   i_idx,
  input  logic               i_wr_pos,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic               i_wr_op,
  input  logic [OP_W-1:0]    i_opcode,
  input  logic               i_wr_flag,
  input  logic               i_loaded,
  input  logic               i_destruido,
  output entry_t             o_rd
);

  entry_t r_mem [N_ENTRIES];

  // Entry storage: reset clears everything, otherwise each field group writes on its own strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(N_ENTRIES); i++) r_mem[i] <= '0;
    end else begin
      if (i_wr_pos) begin
        r_mem[i_idx].x <= i_x;
        r_mem[i_idx].y <= i_y;
      end
      if (i_wr_op) r_mem[i_idx].opcode <= i_opcode;
      if (i_wr_flag) begin
        r_mem[i_idx].loaded    <= i_loaded;
        r_mem[i_idx].destruido <= i_destruido;
      end
    end
  end

  assign o_rd = r_mem[i_idx];

endmodule

// File: rtl/tiro.sv
// tiro: entry counter, ship register, +/-1 adder and position muxing over a 16-entry table.
// Build option: TIRO_DEBUG_EN exposes the counter and adder result on the db_* taps.
module tiro
  import tiro_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  tiro_if.slave  bus
);

  logic [IDX_W-1:0]   r_cnt;
  logic [COORD_W-1:0] r_ship_x;
  logic [COORD_W-1:0] r_ship_y;
  entry_t             w_rd;
  pos_sel_e           w_sel;
  logic [COORD_W-1:0] w_operand;
  logic [SUM_W-1:0]   w_sum;
  logic [COORD_W-1:0] w_new_x;
  logic [COORD_W-1:0] w_new_y;
  logic               w_wr_pos;
  logic               w_wr_op;

  assign w_sel = pos_sel_e'(bus.select_mux_pos);

  // Entry counter: global reset, then local clear, then increment (wraps naturally)
  always_ff @(posedge clock) begin
    if (reset || bus.reset_cont) r_cnt <= '0;
    else if (bus.conta_contador) r_cnt <= r_cnt + IDX_W'(1);
  end

  // Ship register: clear wins over load
  always_ff @(posedge clock) begin
    if (reset || bus.reset_reg_nave) begin
      r_ship_x <= '0;
      r_ship_y <= '0;
    end else if (bus.enable_reg_nave) begin
      r_ship_x <= bus.aste_coor_x;
      r_ship_y <= bus.aste_coor_y;
    end
  end

  // +/-1 on the selected axis; bit 4 carries the carry/borrow
  always_comb begin
    w_operand = bus.select_mux_coor ? w_rd.y : w_rd.x;
    if (bus.select_soma_sub) w_sum = {1'b0, w_operand} - SUM_W'(1);
    else                     w_sum = {1'b0, w_operand} + SUM_W'(1);
  end

  // Position write source and write strobes
  always_comb begin
    w_new_x  = w_rd.x;
    w_new_y  = w_rd.y;
    w_wr_pos = 1'b0;
    w_wr_op  = 1'b0;
    unique case (w_sel)
      POS_EXT: begin
        w_new_x  = bus.aste_coor_x;
        w_new_y  = bus.aste_coor_y;
        w_wr_pos = bus.enable_mem_aste;
      end
      POS_ADDER: begin
        if (bus.select_mux_coor) w_new_y = w_sum[COORD_W-1:0];
        else                     w_new_x = w_sum[COORD_W-1:0];
        w_wr_pos = bus.enable_mem_aste;
      end
      POS_SHIP: begin
        w_new_x  = r_ship_x;
        w_new_y  = r_ship_y;
        w_wr_pos = bus.enable_mem_aste;
        w_wr_op  = bus.enable_mem_aste;
      end
      POS_HOLD: ;
      default: ;
    endcase
  end

  tiro_mem u_mem (
    .clock       (clock),
    .reset       (reset),
    .i_idx       (r_cnt),
    .i_wr_pos    (w_wr_pos),
    .i_x         (w_new_x),
    .i_y         (w_new_y),
    .i_wr_op     (w_wr_op),
    .i_opcode    ({bus.select_mux_coor, bus.select_soma_sub}),
    .i_wr_flag   (bus.enable_mem_load),
    .i_loaded    (bus.new_load),
    .i_destruido (bus.new_destruido),
    .o_rd        (w_rd)
  );

  assign bus.x_borda_min  = (w_rd.x == '0);
  assign bus.x_borda_max  = (w_rd.x == '1);
  assign bus.y_borda_min  = (w_rd.y == '0);
  assign bus.y_borda_max  = (w_rd.y == '1);
  assign bus.rco_contador = (r_cnt == '1);
  assign bus.loaded       = w_rd.loaded;
  assign bus.opcode       = w_rd.opcode;
  assign bus.colisao      = w_rd.loaded & ~w_rd.destruido &
                            (w_rd.x == bus.aste_coor_x) & (w_rd.y == bus.aste_coor_y);

`ifdef TIRO_DEBUG_EN
  assign bus.db_contador           = r_cnt;
  assign bus.db_wire_saida_som_sub = w_sum;
`else
  logic [SUM_W-1:0] w_unused_sum;
  assign w_unused_sum              = w_sum;
  assign bus.db_contador           = '0;
  assign bus.db_wire_saida_som_sub = '0;
`endif

endmodule

// File: tb/tb_tiro.sv
// tiro bench: directed scenarios plus random traffic, every cycle checked against a table model.
module tb_tiro;
  import tiro_pkg::*;

  logic clock;
  logic reset;
  int   n_err;
  int   n_chk;

  tiro_if u_if ();

  tiro u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: plain arrays of entry fields
  int m_x [16];
  int m_y [16];
  int m_op[16];
  int m_ld[16];
  int m_ds[16];
  int m_cnt;
  int m_sx;
  int m_sy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sum5();
    int op;
    op = u_if.select_mux_coor ? m_y[m_cnt] : m_x[m_cnt];
    return u_if.select_soma_sub ? (op + 31) % 32 : op + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_op[i] = 0; m_ld[i] = 0; m_ds[i] = 0;
    end
    m_cnt = 0; m_sx = 0; m_sy = 0;
  endtask

  // Next state from the inputs present at the clock edge
  task automatic model_edge();
    int i;
    int s;
    if (reset) begin
      model_reset();
      return;
    end
    i = m_cnt;
    s = sum5() % 16;
    if (u_if.enable_mem_aste) begin
      case (u_if.select_mux_pos)
        2'b00: begin m_x[i] = int'(u_if.aste_coor_x); m_y[i] = int'(u_if.aste_coor_y); end
        2'b01: if (u_if.select_mux_coor) m_y[i] = s; else m_x[i] = s;
        2'b10: begin
          m_x[i] = m_sx; m_y[i] = m_sy;
          m_op[i] = 2 * int'(u_if.select_mux_coor) + int'(u_if.select_soma_sub);
        end
        default: ;
      endcase
    end
    if (u_if.enable_mem_load) begin
      m_ld[i] = int'(u_if.new_load);
      m_ds[i] = int'(u_if.new_destruido);
    end
    if (u_if.reset_reg_nave) begin m_sx = 0; m_sy = 0; end
    else if (u_if.enable_reg_nave) begin m_sx = int'(u_if.aste_coor_x); m_sy = int'(u_if.aste_coor_y); end
    if (u_if.reset_cont) m_cnt = 0;
    else if (u_if.conta_contador) m_cnt = (m_cnt + 1) % 16;
  endtask

  task automatic check_outputs();
    int i;
    int col;
    i = m_cnt;
    col = (m_ld[i] == 1 && m_ds[i] == 0 && m_x[i] == int'(u_if.aste_coor_x) &&
           m_y[i] == int'(u_if.aste_coor_y)) ? 1 : 0;
    check("x_borda_min", 32'(u_if.x_borda_min), 32'(m_x[i] == 0));
    check("x_borda_max", 32'(u_if.x_borda_max), 32'(m_x[i] == 15));
    check("y_borda_min", 32'(u_if.y_borda_min), 32'(m_y[i] == 0));
    check("y_borda_max", 32'(u_if.y_borda_max), 32'(m_y[i] == 15));
    check("rco",         32'(u_if.rco_contador), 32'(m_cnt == 15));
    check("loaded",      32'(u_if.loaded), 32'(m_ld[i]));
    check("opcode",      32'(u_if.opcode), 32'(m_op[i]));
    check("colisao",     32'(u_if.colisao), 32'(col));
`ifdef TIRO_DEBUG_EN
    check("db_cont",     32'(u_if.db_contador), 32'(m_cnt));
    check("db_sum",      32'(u_if.db_wire_saida_som_sub), 32'(sum5()));
`else
    check("db_cont",     32'(u_if.db_contador), 32'(0));
    check("db_sum",      32'(u_if.db_wire_saida_som_sub), 32'(0));
`endif
  endtask

  // One cycle: check settled outputs, clock, advance the model
  task automatic step();
    #1;
    check_outputs();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    u_if.conta_contador  = 1'b0;
    u_if.reset_cont      = 1'b0;
    u_if.select_mux_pos  = 2'b11;
    u_if.select_mux_coor = 1'b0;
    u_if.select_soma_sub = 1'b0;
    u_if.enable_reg_nave = 1'b0;
    u_if.reset_reg_nave  = 1'b0;
    u_if.enable_mem_aste = 1'b0;
    u_if.enable_mem_load = 1'b0;
    u_if.new_load        = 1'b0;
    u_if.new_destruido   = 1'b0;
  endtask

  task automatic set_aste(input int x, input int y);
    u_if.aste_coor_x = 4'(x);
    u_if.aste_coor_y = 4'(y);
  endtask

  task automatic rand_inputs();
    reset                = ($urandom_range(0, 63) == 0);
    u_if.reset_cont      = ($urandom_range(0, 15) == 0);
    u_if.conta_contador  = 1'($urandom_range(0, 1));
    u_if.select_mux_pos  = 2'($urandom_range(0, 3));
    u_if.select_mux_coor = 1'($urandom_range(0, 1));
    u_if.select_soma_sub = 1'($urandom_range(0, 1));
    u_if.enable_reg_nave = ($urandom_range(0, 3) == 0);
    u_if.reset_reg_nave  = ($urandom_range(0, 15) == 0);
    u_if.enable_mem_aste = 1'($urandom_range(0, 1));
    u_if.enable_mem_load = ($urandom_range(0, 2) == 0);
    u_if.new_load        = ($urandom_range(0, 3) != 0);
    u_if.new_destruido   = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 1) == 1) set_aste(m_x[m_cnt], m_y[m_cnt]);
    else if ($urandom_range(0, 3) == 0) set_aste(15 * $urandom_range(0, 1), 15 * $urandom_range(0, 1));
    else set_aste($urandom_range(0, 15), $urandom_range(0, 15));
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    model_reset();
    idle_inputs();
    set_aste(0, 0);
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Post-reset state
    #1;
    check("rst_rco", 32'(u_if.rco_contador), 32'(0));
    check("rst_col", 32'(u_if.colisao), 32'(0));
    check("rst_ld",  32'(u_if.loaded), 32'(0));
    check("rst_op",  32'(u_if.opcode), 32'(0));
    check("rst_xmn", 32'(u_if.x_borda_min), 32'(1));
    check("rst_ymn", 32'(u_if.y_borda_min), 32'(1));
    check("rst_xmx", 32'(u_if.x_borda_max), 32'(0));

    // External write of (7,0) into entry 0
    u_if.reset_cont = 1'b1; step(); u_if.reset_cont = 1'b0;
    set_aste(7, 0); u_if.select_mux_pos = 2'b00; u_if.enable_mem_aste = 1'b1; step();
    u_if.enable_mem_aste = 1'b0; u_if.select_mux_pos = 2'b11; step();
    check("w70_ymin", 32'(u_if.y_borda_min), 32'(1));
    check("w70_xmin", 32'(u_if.x_borda_min), 32'(0));
    check("w70_col",  32'(u_if.colisao), 32'(0));

    // Flag writes and collision
    u_if.enable_mem_load = 1'b1; u_if.new_load = 1'b1; u_if.new_destruido = 1'b0; step();
    u_if.enable_mem_load = 1'b0; step();
    check("ld_loaded", 32'(u_if.loaded), 32'(1));
    check("ld_col",    32'(u_if.colisao), 32'(1));
    set_aste(7, 1); #1;
    check("ld_col_miss", 32'(u_if.colisao), 32'(0));
    set_aste(7, 0);
    u_if.enable_mem_load = 1'b1; u_if.new_destruido = 1'b1; step();
    u_if.enable_mem_load = 1'b0; step();
    check("ds_col", 32'(u_if.colisao), 32'(0));

    // Adder carry at x=15 then write back via the adder path
    set_aste(15, 0); u_if.select_mux_pos = 2'b00; u_if.enable_mem_aste = 1'b1; step();
    u_if.select_mux_pos = 2'b01; u_if.select_mux_coor = 1'b0; u_if.select_soma_sub = 1'b0;
    step();
    u_if.enable_mem_aste = 1'b0; u_if.select_mux_pos = 2'b11; step();
    check("add_xmin", 32'(u_if.x_borda_min), 32'(1));
    // Borrow at y=0 with the adder write disabled
    u_if.select_mux_coor = 1'b1; u_if.select_soma_sub = 1'b1; step();

    // Ship register write captures opcode
    set_aste(3, 4); u_if.enable_reg_nave = 1'b1; step(); u_if.enable_reg_nave = 1'b0;
    set_aste(9, 9);
    u_if.select_mux_pos = 2'b10; u_if.select_mux_coor = 1'b1; u_if.select_soma_sub = 1'b1;
    u_if.enable_mem_aste = 1'b1; step();
    u_if.enable_mem_aste = 1'b0; u_if.select_mux_pos = 2'b11; step();
    check("ship_op", 32'(u_if.opcode), 32'(3));

    // Full count cycle and wrap
    u_if.conta_contador = 1'b1;
    for (int k = 0; k < 16; k++) step();
    u_if.conta_contador = 1'b0; step();
    check("wrap_rco", 32'(u_if.rco_contador), 32'(0));

    // Reset in the middle of counting
    u_if.conta_contador = 1'b1;
    for (int k = 0; k < 5; k++) step();
    reset = 1'b1; step(); reset = 1'b0; u_if.conta_contador = 1'b0; step();
    check("mid_rst_ymin", 32'(u_if.y_borda_min), 32'(1));
    check("mid_rst_op",   32'(u_if.opcode), 32'(0));

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      rand_inputs();
      step();
    end
    reset = 1'b0;
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
